// File: rtl/rv32_bus_pkg.sv
// rv32_bus_pkg: shared types for the instruction/data bus arbiter.
//   rv32_bus_state_t       - arbiter FSM state
//   rv32_bus_grant_t       - which requester owns the bus (shared with the hazard unit)
//   RV32_BUS_TIMEOUT_WIDTH - width of the bus wait counter
package rv32_bus_pkg;
    typedef enum logic [1:0] {BUS_IDLE, BUS_INSTR, BUS_DATA} rv32_bus_state_t;
    typedef enum logic {GRANT_INSTR, GRANT_DATA} rv32_bus_grant_t;
    localparam int RV32_BUS_TIMEOUT_WIDTH = 8;
endpackage

// File: rtl/rv32_bus_timeout.sv
// rv32_bus_timeout: bus wait-state counter with timeout detection.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the counter (new grant)
//   inc        : count one wait cycle
//   expired    : this wait cycle is the TIMEOUT_CYCLES-th with no ready (0 disables)
module rv32_bus_timeout
    import rv32_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam logic [RV32_BUS_TIMEOUT_WIDTH-1:0] LIMIT = RV32_BUS_TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [RV32_BUS_TIMEOUT_WIDTH-1:0] count_q, count_d;

    always_comb count_d = clear ? '0 : inc ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) count_q <= '0;
        else       count_q <= count_d;

    // The counter holds completed wait cycles; the current one is the last allowed when it equals LIMIT.
    assign expired = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);
endmodule

// File: rtl/rv32_bus_arbiter.sv
// rv32_bus_arbiter: single-outstanding arbiter sharing one memory port between fetch and mem stage.
//   clk, reset                 : clock, asynchronous active-high reset
//   instr_* in/out             : fetch read request, registered read data, ready/fault pulses
//   data_* in/out              : load/store request, registered read data, ready/fault pulses
//   mem_* out                  : registered bus address/strobes/write data/byte enables
//   mem_read_value_in, mem_ready_in, mem_fault_in : bus response
module rv32_bus_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_read_in,
    input  logic [31:0] instr_address_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_ready_out,
    output logic        instr_fault_out,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [31:0] data_address_in,
    input  logic [31:0] data_write_value_in,
    input  logic [3:0]  data_write_mask_in,
    output logic [31:0] data_read_value_out,
    output logic        data_ready_out,
    output logic        data_fault_out,
    output logic [31:0] mem_address_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [31:0] mem_write_value_out,
    output logic [3:0]  mem_write_mask_out,
    input  logic [31:0] mem_read_value_in,
    input  logic        mem_ready_in,
    input  logic        mem_fault_in
);
    rv32_bus_state_t state_q, state_d;
    rv32_bus_grant_t last_grant_q, last_grant_d;
    logic [31:0] mem_address_q, mem_address_d, mem_write_value_q, mem_write_value_d;
    logic [3:0]  mem_write_mask_q, mem_write_mask_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [31:0] instr_value_q, instr_value_d, data_value_q, data_value_d;
    logic        instr_ready_q, instr_ready_d, instr_fault_q, instr_fault_d;
    logic        data_ready_q, data_ready_d, data_fault_q, data_fault_d;
    logic        data_req, pick_instr, clear, expired, busy, done, fault;
    logic [31:0] rvalue;

    assign data_req   = data_read_in | data_write_in;
    // Fetch loses ties unless data owned the previous grant, so neither side can starve.
    assign pick_instr = instr_read_in && (!data_req || last_grant_q == GRANT_DATA);
    assign busy       = state_q != BUS_IDLE;
    assign done       = mem_ready_in || expired;
    // A timeout completes like a response with fault set and zero data.
    assign fault      = !mem_ready_in || mem_fault_in;
    assign rvalue     = mem_ready_in ? mem_read_value_in : '0;
    assign clear      = !busy && (instr_read_in || data_req);

    rv32_bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .inc    (busy && !mem_ready_in),
        .expired(expired)
    );

    always_comb begin
        state_d           = state_q;
        last_grant_d      = last_grant_q;
        mem_address_d     = mem_address_q;
        mem_write_value_d = mem_write_value_q;
        mem_write_mask_d  = mem_write_mask_q;
        mem_read_d        = mem_read_q;
        mem_write_d       = mem_write_q;
        instr_value_d     = instr_value_q;
        data_value_d      = data_value_q;
        instr_ready_d     = 1'b0;
        instr_fault_d     = 1'b0;
        data_ready_d      = 1'b0;
        data_fault_d      = 1'b0;
        if (!busy) begin
            if (pick_instr) begin
                state_d           = BUS_INSTR;
                last_grant_d      = GRANT_INSTR;
                mem_address_d     = instr_address_in & 32'hFFFF_FFFC;
                mem_write_value_d = '0;
                mem_write_mask_d  = '0;
                mem_read_d        = 1'b1;
                mem_write_d       = 1'b0;
            end else if (data_req) begin
                state_d           = BUS_DATA;
                last_grant_d      = GRANT_DATA;
                mem_address_d     = data_address_in & 32'hFFFF_FFFC;
                mem_write_value_d = data_write_value_in;
                mem_write_mask_d  = data_write_mask_in;
                mem_read_d        = !data_write_in;
                mem_write_d       = data_write_in;
            end
        end else if (done) begin
            state_d     = BUS_IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            if (state_q == BUS_INSTR) begin
                instr_ready_d = 1'b1;
                instr_fault_d = fault;
                instr_value_d = rvalue;
            end else begin
                data_ready_d = 1'b1;
                data_fault_d = fault;
                data_value_d = mem_write_q ? '0 : rvalue;
            end
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q           <= BUS_IDLE;
            last_grant_q      <= GRANT_INSTR;
            mem_address_q     <= '0;
            mem_write_value_q <= '0;
            mem_write_mask_q  <= '0;
            mem_read_q        <= 1'b0;
            mem_write_q       <= 1'b0;
            instr_value_q     <= '0;
            data_value_q      <= '0;
            instr_ready_q     <= 1'b0;
            instr_fault_q     <= 1'b0;
            data_ready_q      <= 1'b0;
            data_fault_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            last_grant_q      <= last_grant_d;
            mem_address_q     <= mem_address_d;
            mem_write_value_q <= mem_write_value_d;
            mem_write_mask_q  <= mem_write_mask_d;
            mem_read_q        <= mem_read_d;
            mem_write_q       <= mem_write_d;
            instr_value_q     <= instr_value_d;
            data_value_q      <= data_value_d;
            instr_ready_q     <= instr_ready_d;
            instr_fault_q     <= instr_fault_d;
            data_ready_q      <= data_ready_d;
            data_fault_q      <= data_fault_d;
        end

    assign instr_read_value_out = instr_value_q;
    assign instr_ready_out      = instr_ready_q;
    assign instr_fault_out      = instr_fault_q;
    assign data_read_value_out  = data_value_q;
    assign data_ready_out       = data_ready_q;
    assign data_fault_out       = data_fault_q;
    assign mem_address_out      = mem_address_q;
    assign mem_read_out         = mem_read_q;
    assign mem_write_out        = mem_write_q;
    assign mem_write_value_out  = mem_write_value_q;
    assign mem_write_mask_out   = mem_write_mask_q;
endmodule
